// File: rtl/contador_bcd_mod.sv
// contador_bcd_mod: two-digit BCD modulo counter (modulus 2..100).
//
// Counts up or down over 0..MODULO-1. It supports a synchronous preset load
// that is checked for validity. Wrap edges are reported as registered
// one-cycle pulses (carry on up-wrap, borrow on down-wrap). A combinational
// terminal flag lets a cascade pre-decode the wrap.
//
// Ports:
//   clk           system clock, all state on rising edge
//   rst           synchronous reset, active-high -> INIT_VAL, pulses cleared
//   enable        count tick, one step per cycle while high
//   up_down       1 = count up, 0 = count down
//   load          preset request (priority over enable)
//   load_unidade  preset units digit (BCD)
//   load_dezena   preset tens digit (BCD)
//   unidade       units digit, registered
//   dezena        tens digit, registered
//   carry         one-cycle pulse, high while the counter shows the up-wrapped 00
//   borrow        one-cycle pulse, high while the counter shows the down-wrapped max
//   load_err      one-cycle pulse on a rejected preset
//   at_term       1 when value == MODULO-1 (up) or 00 (down)
module contador_bcd_mod #(
    parameter int MODULO   = 60,
    parameter int DEZ_W    = 3,
    parameter int INIT_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [3:0]       load_unidade,
    input  logic [DEZ_W-1:0] load_dezena,
    output logic [3:0]       unidade,
    output logic [DEZ_W-1:0] dezena,
    output logic             carry,
    output logic             borrow,
    output logic             load_err,
    output logic             at_term
);

    // Parameter legality, checked at elaboration.
    if (MODULO < 2 || MODULO > 100) begin : g_bad_modulo
        $error("contador_bcd_mod: MODULO must be in 2..100");
    end
    if (DEZ_W < 1 || DEZ_W > 4 || ((MODULO - 1) / 10) >= (1 << DEZ_W)) begin : g_bad_dez_w
        $error("contador_bcd_mod: DEZ_W cannot hold the tens digit of MODULO-1");
    end
    if (INIT_VAL < 0 || INIT_VAL >= MODULO) begin : g_bad_init
        $error("contador_bcd_mod: INIT_VAL must be in 0..MODULO-1");
    end

    localparam logic [3:0]       TERM_U = 4'((MODULO - 1) % 10);
    localparam logic [DEZ_W-1:0] TERM_D = DEZ_W'((MODULO - 1) / 10);
    localparam logic [3:0]       INIT_U = 4'(INIT_VAL % 10);
    localparam logic [DEZ_W-1:0] INIT_D = DEZ_W'(INIT_VAL / 10);

    logic             is_max;
    logic             is_zero;
    logic [7:0]       load_val;
    logic             load_ok;
    logic [3:0]       nxt_u;
    logic [DEZ_W-1:0] nxt_d;
    logic             nxt_carry;
    logic             nxt_borrow;
    logic             nxt_err;

    assign is_max  = (dezena == TERM_D) && (unidade == TERM_U);
    assign is_zero = (dezena == '0) && (unidade == 4'd0);
    assign at_term = up_down ? is_max : is_zero;

    // The tens digit is at most 15 and the units digit at most 15, so the
    // binary value fits in 8 bits. The units <= 9 test rejects non-BCD units.
    // The value < MODULO test implies tens <= 9.
    assign load_val = 8'(load_dezena) * 8'd10 + 8'(load_unidade);
    assign load_ok  = (load_unidade <= 4'd9) && (load_val < 8'(MODULO));

    always_comb begin
        nxt_u      = unidade;
        nxt_d      = dezena;
        nxt_carry  = 1'b0;
        nxt_borrow = 1'b0;
        nxt_err    = 1'b0;
        if (load) begin
            // A load cycle ignores enable entirely, so it never wraps.
            if (load_ok) begin
                nxt_u = load_unidade;
                nxt_d = load_dezena;
            end else begin
                nxt_err = 1'b1;
            end
        end else if (enable) begin
            if (up_down) begin
                if (is_max) begin
                    nxt_u     = 4'd0;
                    nxt_d     = '0;
                    nxt_carry = 1'b1;
                end else if (unidade == 4'd9) begin
                    nxt_u = 4'd0;
                    nxt_d = dezena + DEZ_W'(1);
                end else begin
                    nxt_u = unidade + 4'd1;
                end
            end else begin
                if (is_zero) begin
                    nxt_u      = TERM_U;
                    nxt_d      = TERM_D;
                    nxt_borrow = 1'b1;
                end else if (unidade == 4'd0) begin
                    nxt_u = 4'd9;
                    nxt_d = dezena - DEZ_W'(1);
                end else begin
                    nxt_u = unidade - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            unidade  <= INIT_U;
            dezena   <= INIT_D;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            unidade  <= nxt_u;
            dezena   <= nxt_d;
            carry    <= nxt_carry;
            borrow   <= nxt_borrow;
            load_err <= nxt_err;
        end
    end

endmodule

// File: tb/tb_contador_bcd_mod.sv
// Bench for contador_bcd_mod: three instances (mod-60, mod-24, mod-60 with
// INIT_VAL=12). Each stimulus step pushes the expected outputs, computed from
// an integer value model, onto a queue. The scenario task pops and compares
// after the clock edge.
module tb_contador_bcd_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v = 3'b111;
    logic [2:0] ld_v  = 3'b000;
    logic [2:0] en_v  = 3'b000;
    logic [2:0] ud_v  = 3'b111;
    logic [3:0] lu_s [3];
    logic [3:0] lz_s [3];

    logic [3:0] u0, u1, u2;
    logic [2:0] d0;
    logic [1:0] d1;
    logic [2:0] d2;
    logic [2:0] cy, bw, er, at;

    contador_bcd_mod #(.MODULO(60), .DEZ_W(3), .INIT_VAL(0)) dut_a (
        .clk(clk), .rst(rst_v[0]), .enable(en_v[0]), .up_down(ud_v[0]), .load(ld_v[0]),
        .load_unidade(lu_s[0]), .load_dezena(lz_s[0][2:0]),
        .unidade(u0), .dezena(d0), .carry(cy[0]), .borrow(bw[0]),
        .load_err(er[0]), .at_term(at[0]));

    contador_bcd_mod #(.MODULO(24), .DEZ_W(2), .INIT_VAL(0)) dut_b (
        .clk(clk), .rst(rst_v[1]), .enable(en_v[1]), .up_down(ud_v[1]), .load(ld_v[1]),
        .load_unidade(lu_s[1]), .load_dezena(lz_s[1][1:0]),
        .unidade(u1), .dezena(d1), .carry(cy[1]), .borrow(bw[1]),
        .load_err(er[1]), .at_term(at[1]));

    contador_bcd_mod #(.MODULO(60), .DEZ_W(3), .INIT_VAL(12)) dut_c (
        .clk(clk), .rst(rst_v[2]), .enable(en_v[2]), .up_down(ud_v[2]), .load(ld_v[2]),
        .load_unidade(lu_s[2]), .load_dezena(lz_s[2][2:0]),
        .unidade(u2), .dezena(d2), .carry(cy[2]), .borrow(bw[2]),
        .load_err(er[2]), .at_term(at[2]));

    typedef struct packed {
        logic [3:0] u;
        logic [3:0] d;
        logic       c;
        logic       b;
        logic       e;
        logic       t;
    } obs_t;

    typedef struct packed {
        logic       r;
        logic       l;
        logic [3:0] lu;
        logic [3:0] lz;
        logic       e;
        logic       ud;
    } stim_t;

    int   MODV  [3] = '{60, 24, 60};
    int   INITV [3] = '{0, 0, 12};
    int   LZM   [3] = '{7, 3, 7};
    int   mv    [3] = '{0, 0, 0};
    obs_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic stim_t mk(logic r, logic l, logic [3:0] lu, logic [3:0] lz,
                                 logic e, logic ud);
        stim_t s;
        s.r = r; s.l = l; s.lu = lu; s.lz = lz; s.e = e; s.ud = ud;
        return s;
    endfunction

    function automatic obs_t observe(int k);
        obs_t o;
        case (k)
            0:       o = '{u: u0, d: {1'b0, d0},  c: cy[0], b: bw[0], e: er[0], t: at[0]};
            1:       o = '{u: u1, d: {2'b00, d1}, c: cy[1], b: bw[1], e: er[1], t: at[1]};
            default: o = '{u: u2, d: {1'b0, d2},  c: cy[2], b: bw[2], e: er[2], t: at[2]};
        endcase
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("d=%0d u=%0d carry=%b borrow=%b load_err=%b at_term=%b",
                         o.d, o.u, o.c, o.b, o.e, o.t);
    endfunction

    // Drive one cycle of stimulus to instance k and push the expected result.
    // The other instances are idle that cycle.
    task automatic drive(int k, stim_t s);
        obs_t x;
        int   m, lzv, lv;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            if (j != k) begin
                rst_v[j] = 1'b0; ld_v[j] = 1'b0; en_v[j] = 1'b0;
            end
        end
        rst_v[k] = s.r; ld_v[k] = s.l; en_v[k] = s.e; ud_v[k] = s.ud;
        lu_s[k] = s.lu; lz_s[k] = s.lz;
        m   = MODV[k];
        lzv = int'(s.lz) & LZM[k];
        x   = '0;
        if (s.r) begin
            mv[k] = INITV[k];
        end else if (s.l) begin
            lv = 10 * lzv + int'(s.lu);
            if (s.lu <= 4'd9 && lv < m) mv[k] = lv;
            else x.e = 1'b1;
        end else if (s.e) begin
            if (s.ud) begin
                if (mv[k] == m - 1) begin mv[k] = 0; x.c = 1'b1; end
                else mv[k] = mv[k] + 1;
            end else begin
                if (mv[k] == 0) begin mv[k] = m - 1; x.b = 1'b1; end
                else mv[k] = mv[k] - 1;
            end
        end
        x.u = 4'(mv[k] % 10);
        x.d = 4'(mv[k] / 10);
        x.t = s.ud ? (mv[k] == m - 1) : (mv[k] == 0);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t want, got;
        for (int k = 0; k < 3; k++) begin
            drive(k, mk(1, 0, 0, 0, 1, 1));
            want = exp_q.pop_front(); got = observe(k); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset[%0d]: got %s, want %s", k, fmt(got), fmt(want));
            end
        end
        checks++;
        if (d2 !== 3'd1 || u2 !== 4'd2) begin
            failures++;
            $display("FAIL init_val12: got d=%0d u=%0d, want d=1 u=2", d2, u2);
        end
    endtask

    task automatic test_up_wrap();
        stim_t s[$];
        obs_t  want, got;
        s = '{mk(0,1,8,5,0,1), mk(0,0,0,0,1,1), mk(0,0,0,0,1,1), mk(0,0,0,0,1,1),
              mk(0,0,0,0,0,1), mk(0,1,9,0,0,1), mk(0,0,0,0,1,1)};
        for (int i = 0; i < s.size(); i++) begin
            drive(0, s[i]);
            want = exp_q.pop_front(); got = observe(0); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL up_wrap step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_down_wrap();
        stim_t s[$];
        obs_t  want, got;
        s = '{mk(0,1,0,0,0,0), mk(0,0,0,0,1,0), mk(0,0,0,0,1,0), mk(0,0,0,0,0,0),
              mk(0,1,0,1,0,0), mk(0,0,0,0,1,0), mk(0,0,0,0,1,1), mk(0,0,0,0,1,0)};
        for (int i = 0; i < s.size(); i++) begin
            drive(0, s[i]);
            want = exp_q.pop_front(); got = observe(0); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL down_wrap step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_mod24();
        stim_t s[$];
        obs_t  want, got;
        s = '{mk(0,1,2,2,0,1), mk(0,0,0,0,1,1), mk(0,0,0,0,1,1), mk(0,0,0,0,1,0),
              mk(0,0,0,0,1,0), mk(0,1,4,2,0,1), mk(0,1,9,1,0,1), mk(0,0,0,0,1,1)};
        for (int i = 0; i < s.size(); i++) begin
            drive(1, s[i]);
            want = exp_q.pop_front(); got = observe(1); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL mod24 step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_load();
        stim_t s[$];
        obs_t  want, got;
        s = '{mk(0,1,4'hA,1,0,1), mk(0,0,0,0,0,1), mk(0,1,0,6,0,1), mk(0,1,5,4,0,1),
              mk(0,0,0,0,0,1), mk(0,1,9,5,0,1), mk(0,1,1,2,1,1), mk(0,1,9,5,0,1),
              mk(0,1,0,7,1,1), mk(0,0,0,0,0,1)};
        for (int i = 0; i < s.size(); i++) begin
            drive(0, s[i]);
            want = exp_q.pop_front(); got = observe(0); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL load step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_enable_pulsed();
        obs_t want, got;
        drive(0, mk(0, 1, 7, 5, 0, 1));
        want = exp_q.pop_front(); got = observe(0); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL enable_pulsed preset: got %s, want %s", fmt(got), fmt(want));
        end
        for (int i = 0; i < 12; i++) begin
            drive(0, mk(0, 0, 0, 0, (i % 3) == 0, 1));
            want = exp_q.pop_front(); got = observe(0); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL enable_pulsed step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_reset_after_wrap();
        stim_t s[$];
        obs_t  want, got;
        s = '{mk(0,1,9,5,0,1), mk(0,0,0,0,1,1), mk(1,0,0,0,1,1), mk(0,0,0,0,1,0),
              mk(1,0,0,0,1,0)};
        for (int k = 0; k < 3; k += 2) begin
            for (int i = 0; i < s.size(); i++) begin
                drive(k, s[i]);
                want = exp_q.pop_front(); got = observe(k); checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL reset_after_wrap[%0d] step %0d: got %s, want %s",
                             k, i, fmt(got), fmt(want));
                end
            end
        end
    endtask

    task automatic test_random();
        stim_t st;
        obs_t  want, got;
        for (int i = 0; i < 300; i++) begin
            st.r  = ($urandom_range(0, 49) == 0);
            st.l  = ($urandom_range(0, 7) == 0);
            st.lu = 4'($urandom_range(0, 15));
            st.lz = 4'($urandom_range(0, 7));
            st.e  = ($urandom_range(0, 3) != 0);
            st.ud = ($urandom_range(0, 4) != 0);
            drive(i % 2, st);
            want = exp_q.pop_front(); got = observe(i % 2); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL random[%0d] step %0d: got %s, want %s",
                         i % 2, i, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            lu_s[j] = 4'd0;
            lz_s[j] = 4'd0;
        end
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_mod24();
        test_load();
        test_enable_pulsed();
        test_reset_after_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
